// File: rtl/pmem_scheduler_pkg.sv
// Shared types for the physical-memory scheduler slice.
//   arb_owner_t      : which requester currently owns the pmem port
//   sched_state_t    : scheduler FSM state
//   LINE_OFFSET_BITS : byte-offset width of one 256-bit cache line
//   line_align()     : clears the line-offset bits of an address
//   lost_next()      : next value of a saturating starvation counter
package rv32i_types;

    localparam int unsigned LINE_OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        ARB_NONE,
        ARB_DATA,
        ARB_INSTR,
        ARB_PF
    } arb_owner_t;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } sched_state_t;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & ~((32'd1 << LINE_OFFSET_BITS) - 32'd1);
    endfunction

    // Clear on grant or when not pending; otherwise count one lost grant,
    // holding at 15 instead of wrapping.
    function automatic logic [3:0] lost_next(input logic       pend,
                                             input logic       won,
                                             input logic [3:0] cnt);
        if (!pend || won) return '0;
        if (cnt == 4'hF)  return cnt;
        return cnt + 4'd1;
    endfunction

endpackage

// File: rtl/pmem_scheduler_if.sv
// Physical-memory port bundle.
//   master : scheduler side (drives command, address, write line)
//   slave  : memory side (drives resp and read line)
interface pmem_scheduler_if;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;

    modport master (
        input  pmem_resp, pmem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        output pmem_resp, pmem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/pmem_scheduler_pick.sv
// Combinational winner selection for the pmem port.
//   i_pend_d/i/pf    : requester pending bits
//   i_starve_i/pf    : starvation flags (lost counter reached the limit)
//   o_owner          : winning requester, ARB_NONE if nothing pending
// Order: starved INSTR > starved PF > DATA > INSTR > PF.
module pmem_pick
    import rv32i_types::*;
(
    input  logic       i_pend_d,
    input  logic       i_pend_i,
    input  logic       i_pend_pf,
    input  logic       i_starve_i,
    input  logic       i_starve_pf,
    output arb_owner_t o_owner
);

    always_comb begin
        o_owner = ARB_NONE;
        if (i_pend_i && i_starve_i)        o_owner = ARB_INSTR;
        else if (i_pend_pf && i_starve_pf) o_owner = ARB_PF;
        else if (i_pend_d)                 o_owner = ARB_DATA;
        else if (i_pend_i)                 o_owner = ARB_INSTR;
        else if (i_pend_pf)                o_owner = ARB_PF;
    end

endmodule

// File: rtl/pmem_scheduler.sv
// Three-requester scheduler for the single physical-memory port
// (data cache, instruction cache, next-line prefetcher).
//   clk, rst (sync, active-low)
//   d_read/d_write/d_addr/d_wdata -> d_resp/d_rdata   : data cache
//   i_read/i_addr                 -> i_resp/i_rdata   : instruction cache
//   pf_read/pf_addr               -> pf_resp/pf_rdata : prefetcher
//   pmem                                              : memory port (registered command)
module pmem_scheduler
    import rv32i_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     d_read,
    input  logic                     d_write,
    input  logic [31:0]              d_addr,
    input  logic [255:0]             d_wdata,
    output logic                     d_resp,
    output logic [255:0]             d_rdata,
    input  logic                     i_read,
    input  logic [31:0]              i_addr,
    output logic                     i_resp,
    output logic [255:0]             i_rdata,
    input  logic                     pf_read,
    input  logic [31:0]              pf_addr,
    output logic                     pf_resp,
    output logic [255:0]             pf_rdata,
    pmem_scheduler_if.master         pmem
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    sched_state_t r_state, w_state_next;
    arb_owner_t   r_owner, w_pick;
    logic         r_read, r_write;
    logic [31:0]  r_addr;
    logic [255:0] r_wdata;
    logic [3:0]   r_lost_i, r_lost_pf;

    logic w_pend_d, w_grant, w_done;
    logic w_own_d, w_own_i, w_own_pf;

    assign w_pend_d = d_read | d_write;

    pmem_pick u_pick (
        .i_pend_d    (w_pend_d),
        .i_pend_i    (i_read),
        .i_pend_pf   (pf_read),
        .i_starve_i  (r_lost_i  >= LIMIT),
        .i_starve_pf (r_lost_pf >= LIMIT),
        .o_owner     (w_pick)
    );

    assign w_grant = (r_state == S_IDLE) && (w_pick != ARB_NONE);
    assign w_done  = (r_state == S_BUSY) && pmem.pmem_resp;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_pick != ARB_NONE) w_state_next = S_BUSY;
            S_BUSY:  if (pmem.pmem_resp)     w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Transaction latch: a write wins over a simultaneous data read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_owner <= ARB_NONE;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_owner <= w_pick;
            case (w_pick)
                ARB_DATA: begin
                    r_read  <= ~d_write;
                    r_write <= d_write;
                    r_addr  <= line_align(d_addr);
                    r_wdata <= d_write ? d_wdata : '0;
                end
                ARB_INSTR: begin
                    r_read  <= 1'b1;
                    r_write <= 1'b0;
                    r_addr  <= line_align(i_addr);
                    r_wdata <= '0;
                end
                ARB_PF: begin
                    r_read  <= 1'b1;
                    r_write <= 1'b0;
                    r_addr  <= line_align(pf_addr);
                    r_wdata <= '0;
                end
                default: ;
            endcase
        end else if (w_done) begin
            r_owner <= ARB_NONE;
            r_read  <= 1'b0;
            r_write <= 1'b0;
        end
    end

    // Counters only move on IDLE samples; requests are ignored while BUSY.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lost_i  <= '0;
            r_lost_pf <= '0;
        end else if (r_state == S_IDLE) begin
            r_lost_i  <= lost_next(i_read,  w_pick == ARB_INSTR, r_lost_i);
            r_lost_pf <= lost_next(pf_read, w_pick == ARB_PF,    r_lost_pf);
        end
    end

    assign w_own_d  = (r_state == S_BUSY) && (r_owner == ARB_DATA);
    assign w_own_i  = (r_state == S_BUSY) && (r_owner == ARB_INSTR);
    assign w_own_pf = (r_state == S_BUSY) && (r_owner == ARB_PF);

    assign d_resp   = w_own_d  && pmem.pmem_resp;
    assign i_resp   = w_own_i  && pmem.pmem_resp;
    assign pf_resp  = w_own_pf && pmem.pmem_resp;
    assign d_rdata  = w_own_d  ? pmem.pmem_rdata : '0;
    assign i_rdata  = w_own_i  ? pmem.pmem_rdata : '0;
    assign pf_rdata = w_own_pf ? pmem.pmem_rdata : '0;

    assign pmem.pmem_read    = r_read;
    assign pmem.pmem_write   = r_write;
    assign pmem.pmem_address = r_addr;
    assign pmem.pmem_wdata   = r_wdata;

endmodule

// File: doc/pmem_scheduler.md
# pmem_scheduler

Three-requester scheduler for the single physical-memory port. It shares the port between the data cache, the instruction cache and the next-line instruction prefetcher. Each transaction's address, opcode and write data are latched in registers, and the port is granted by fixed priority with a starvation override. It sits between the cache-line interfaces and physical memory, and drives the pmem port only from registered state.

## Interface
- STARVE_LIMIT, 8: number of grants lost by a pending requester before it is forced to top priority (legal range 1–15).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset.
- d_read, d_write  in  1  data-cache line read / write request; both high in one cycle is illegal.
- d_addr  in  32  data line address.
- d_wdata  in  256  data write line.
- d_resp  out  1  data transaction complete.
- d_rdata  out  256  data read line.
- i_read  in  1  instruction line read request.
- i_addr  in  32  instruction line address.
- i_resp  out  1  instruction transaction complete.
- i_rdata  out  256  instruction read line.
- pf_read  in  1  prefetch line read request; may be withdrawn while ungranted.
- pf_addr  in  32  prefetch line address.
- pf_resp  out  1  prefetch transaction complete.
- pf_rdata  out  256  prefetch read line.
- pmem_resp  in  1  physical memory done.
- pmem_rdata  in  256  physical memory read line.
- pmem_read, pmem_write  out  1  registered memory command.
- pmem_address  out  32  registered line address; bits [4:0] always 0.
- pmem_wdata  out  256  registered write line.

## Operation
- FSM states IDLE and BUSY; owner register ∈ {NONE, DATA, INSTR, PF}.
- IDLE: evaluate pending requests. If any is pending, latch the winner's address, opcode and wdata, set owner, and go to BUSY. If none is pending, stay in IDLE.
- Base priority is DATA > INSTR > PF.
- Starvation override: each of INSTR and PF has a 4-bit lost counter. The counter increments when its requester is pending in IDLE and another requester wins. It clears when that requester is granted, or when it is sampled not pending.
  - A counter ≥ STARVE_LIMIT puts its requester above DATA.
  - If both counters saturate, INSTR beats PF.
  - Counters saturate at 15.
- BUSY: pmem_read/pmem_write come from the latched opcode.
  - On pmem_resp, pulse the owner's resp in the same cycle, then go to IDLE.
  - Clear the command and owner at that edge.
- Read data: {d,i,pf}_rdata = pmem_rdata when owner matches and the state is BUSY, else 0. resp = pmem_resp ∧ BUSY ∧ owner match; non-owners' resp = 0.
- pmem_wdata holds the latched d_wdata for DATA writes, else 0.
- d_read ∧ d_write: write wins. The bench flags this case by assertion.
- pmem_resp in IDLE is ignored: no resp output, no state change.
- Requester inputs are ignored while BUSY. Changes to a requester's address after grant have no effect.
- PF withdrawn before grant: no transaction is issued. PF cannot cancel after grant; its transaction completes normally.

## Timing
- Reset (rst = 0 at an edge): state = IDLE, owner = NONE, counters = 0, pmem_read = pmem_write = 0, pmem_address = 0, pmem_wdata = 0.
  - All resp = 0 and all rdata = 0.
  - Reset mid-BUSY abandons the transaction. The command drops in the cycle after the reset edge, and no resp is issued for it.
- Request sampled in IDLE at cycle t → pmem command asserted at cycle t+1.
- pmem_resp at cycle k → requester resp at cycle k, combinational. The command is low at cycle k+1, in IDLE.
- Requesters must hold their request and operands until resp, then deassert by the following cycle.
- One mandatory IDLE cycle between transactions. Throughput is one line per (memory latency + 1) cycles.
- Minimum request-to-resp latency is 1 cycle, with pmem_resp at t+1.

## Structure
- The shared rv32i_types package gains:
  - arb_owner_t enum {ARB_NONE, ARB_DATA, ARB_INSTR, ARB_PF}.
  - Constant LINE_OFFSET_BITS = 5.
- Sub-module pmem_pick: combinational winner selection from the pending bits and the starvation flags, producing arb_owner_t.
- Counters, latch registers and the FSM stay in pmem_scheduler.

## Test plan
- Reset with rst = 0 for 2 cycles, then d_read, i_read and pf_read high together:
  - pmem_read rises 1 cycle later with pmem_address = d_addr & ~31.
  - INSTR and PF each follow in order, separated by one IDLE cycle.
  - Each resp is 1 cycle wide.
- d_write with d_addr = 0x8000_0024 and d_wdata = {8{32'hDEAD_BEEF}}:
  - pmem_write = 1, pmem_address = 0x8000_0020, pmem_wdata matches.
  - d_resp coincides with pmem_resp, and i_resp stays 0.
- STARVE_LIMIT = 2, continuous back-to-back d_read with i_read held:
  - INSTR is granted on the 3rd arbitration after losing 2, ahead of DATA.
  - Its counter then reads 0.
- pf_read high for 1 cycle during a DATA BUSY, then dropped: no PF transaction is issued and pf_resp never asserts.
- rst = 0 for one cycle in the middle of an INSTR read:
  - The command drops the next cycle.
  - A later pmem_resp produces no i_resp.
  - The next i_read is serviced normally.
- pmem_resp = 1 while IDLE: all resp stay 0 and the state remains IDLE.
